glb_mcast_tx: RTL

- Transmit end of the global multicast bus: the global-buffer side that drives tagged data toward the per-column MultiCaster receivers feeding the PEs.
- Buffers incoming (data, tag) words in a small FIFO and presents each word on the bus.
- Computes the set of target columns from the tag and the per-column IDs, then holds the word until every targeted column has accepted it.
- Sits between the GLB read port and the NUM_COL MultiCaster/PE columns.

---
 rtl/glb_bus_pkg.sv | 35 +++
 rtl/glb_sync_fifo.sv | 47 ++++
 rtl/glb_mcast_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/glb_bus_pkg.sv
// glb_bus_pkg: shared types and tag-matching helpers for the global multicast bus.
package glb_bus_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int MAX_ID_WIDTH   = 16;
    localparam int MAX_COL        = 32;

    typedef enum logic {IDLE, SEND} tx_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_ID_WIDTH-1:0]   tag;
    } bus_word_t;

    function automatic logic [MAX_ID_WIDTH-1:0] bcast_id(input int id_w);
        return MAX_ID_WIDTH'((33'd1 << id_w) - 33'd1);
    endfunction

    // Inputs are zero-extended to the maximum sizes; column IDs keep their packed id_w stride.
    function automatic logic [MAX_COL-1:0] match_mask(
        input logic [MAX_ID_WIDTH-1:0]         tag,
        input logic [MAX_COL*MAX_ID_WIDTH-1:0] ids,
        input int                              num_col,
        input int                              id_w
    );
        logic [MAX_ID_WIDTH-1:0] id;
        match_mask = '0;
        for (int i = 0; i < MAX_COL; i++) begin
            id = ids[i*id_w +: MAX_ID_WIDTH] & bcast_id(id_w);
            if (i < num_col) match_mask[i] = (id == tag) || (tag == bcast_id(id_w));
        end
    endfunction

endpackage

// File: rtl/glb_sync_fifo.sv
// glb_sync_fifo: show-ahead synchronous FIFO with registered occupancy count.
module glb_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/glb_mcast_tx.sv
// glb_mcast_tx: buffers tagged GLB words and holds each on the multicast bus
// until every matching column has accepted it.
module glb_mcast_tx
    import glb_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [ID_WIDTH-1:0]         in_tag,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_COL*ID_WIDTH-1:0] cfg_col_id,
    output logic [DATA_WIDTH-1:0]       bus_data,
    output logic [ID_WIDTH-1:0]         bus_tag,
    output logic                        bus_valid,
    input  logic [NUM_COL-1:0]          pe_ready,
    output logic [NUM_COL-1:0]          pending,
    output logic                        busy,
    output logic [15:0]                 sent_cnt,
    output logic [15:0]                 drop_cnt
);

    logic [DATA_WIDTH-1:0]       head_data, data_q, data_d;
    logic [ID_WIDTH-1:0]         head_tag, tag_q, tag_d;
    logic [NUM_COL-1:0]          match, pending_q, pending_d;
    logic [15:0]                 sent_q, sent_d, drop_q, drop_d;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        full, empty, done, advance;
    tx_state_e                   state_q, state_d;

    // Full is registered, so a pop at full does not reopen the input this cycle.
    assign in_ready = !full && !rst;

    glb_sync_fifo #(.WIDTH(DATA_WIDTH + ID_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .pop_i   (advance),
        .wdata_i ({in_tag, in_data}),
        .rdata_o ({head_tag, head_data}),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign match = NUM_COL'(match_mask(MAX_ID_WIDTH'(head_tag),
                                       (MAX_COL*MAX_ID_WIDTH)'(cfg_col_id), NUM_COL, ID_WIDTH));

    always_comb begin
        done      = state_q == SEND && (pending_q & ~pe_ready) == '0;
        advance   = (state_q == IDLE || done) && !empty;
        state_d   = done ? IDLE : state_q;
        pending_d = state_q == SEND ? pending_q & ~pe_ready : pending_q;
        data_d    = data_q;
        tag_d     = tag_q;
        sent_d    = sent_q + 16'(done);
        drop_d    = drop_q;
        if (advance) begin
            if (|match) begin
                state_d   = SEND;
                data_d    = head_data;
                tag_d     = head_tag;
                pending_d = match;
            end else begin
                state_d = IDLE;
                drop_d  = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            tag_q     <= '0;
            pending_q <= '0;
            sent_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            pending_q <= pending_d;
            sent_q    <= sent_d;
            drop_q    <= drop_d;
        end
    end

    assign bus_valid = state_q == SEND;
    assign bus_data  = data_q;
    assign bus_tag   = tag_q;
    assign pending   = pending_q;
    assign sent_cnt  = sent_q;
    assign drop_cnt  = drop_q;
    assign busy      = count != '0 || bus_valid;

endmodule
